hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 21 ++
 rtl/hazard_match.sv | 33 +++
 rtl/hazard_ctrl.sv | 96 +++++++++
 tb/tb_hazard_ctrl.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU package: forwarding-select encoding and the post-ID tracking entry
// used by the hazard controller and its match encoders.
package hazard_ctrl_pkg;

  // Tracking entries carry addresses at this fixed width; REG_ADDR_W must not exceed it.
  localparam int ADDR_W_MAX = 8;

  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_MAX-1:0] waddr;
    logic                  reg_write;
    logic                  mem_read;
  } track_entry_t;

  function automatic logic writes_reg(input track_entry_t e, input logic [ADDR_W_MAX-1:0] r);
    return e.valid && e.reg_write && (e.waddr == r) && (r != '0);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-producer priority encoder for one ID source operand: returns the
// smallest stage index holding a live write to that register, or FWD_RF.
module hazard_match
  import hazard_ctrl_pkg::*;
#(
  parameter  int DEPTH      = 3,
  parameter  int REG_ADDR_W = 5,
  localparam int FWD_W      = $clog2(DEPTH + 1)
) (
  input  track_entry_t          stages [1:DEPTH],
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  use_src,
  output logic [FWD_W-1:0]      sel,
  output logic                  is_load
);

  logic [ADDR_W_MAX-1:0] src_ext;

  assign src_ext = ADDR_W_MAX'(src);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel     = FWD_W'(FWD_RF);
    is_load = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (use_src && writes_reg(stages[k], src_ext)) begin
        sel     = FWD_W'(k);
        is_load = stages[k].mem_read;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks post-ID instructions, selects forwarding
// sources, stalls on load-use, flushes on taken branches and counts events.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter  int REG_ADDR_W = 5,
  parameter  int DEPTH      = 3,
  parameter  int LOAD_LAT   = 2,
  parameter  int CNT_W      = 32,
  localparam int FWD_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_waddr,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic                  flush_id_exe,
  output logic [FWD_W-1:0]      fwd_a,
  output logic [FWD_W-1:0]      fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  track_entry_t stages [1:DEPTH];
  track_entry_t id_entry;
  logic         load_a;
  logic         load_b;
  logic         load_use;
  logic         flush;

  hazard_match #(.DEPTH(DEPTH), .REG_ADDR_W(REG_ADDR_W)) u_match_rs (
    .stages  (stages),
    .src     (id_rs),
    .use_src (id_use_rs),
    .sel     (fwd_a),
    .is_load (load_a)
  );

  hazard_match #(.DEPTH(DEPTH), .REG_ADDR_W(REG_ADDR_W)) u_match_rt (
    .stages  (stages),
    .src     (id_rt),
    .use_src (id_use_rt),
    .sel     (fwd_b),
    .is_load (load_b)
  );

  // A load is only usable from LOAD_LAT onward; a flush kills ID anyway, so it wins.
  always_comb begin
    flush        = branch_taken && stages[1].valid;
    load_use     = (load_a && (int'(fwd_a) < LOAD_LAT)) ||
                   (load_b && (int'(fwd_b) < LOAD_LAT));
    stall        = load_use && !flush;
    flush_if_id  = flush;
    flush_id_exe = flush;

    id_entry = '0;
    if (id_valid && !stall && !flush) begin
      id_entry.valid     = 1'b1;
      id_entry.waddr     = ADDR_W_MAX'(id_waddr);
      id_entry.reg_write = id_reg_write;
      id_entry.mem_read  = id_mem_read;
    end
  end

  // Enable-register behaviour: reset dominates, otherwise advance only when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        stages[k] <= '0;
      end
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (enable) begin
      stages[1] <= id_entry;
      for (int k = 2; k <= DEPTH; k++) begin
        stages[k] <= stages[k-1];
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a default build and a DEPTH=5/LOAD_LAT=4/CNT_W=4
// build share one stimulus stream and are checked against a queue-based instruction model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] id_waddr;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       branch_taken;

  logic        stall, flush_if_id, flush_id_exe;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;

  logic        stall5, flush_if_id5, flush_id_exe5;
  logic [2:0]  fwd_a5, fwd_b5;
  logic [3:0]  stall_cnt5, flush_cnt5;

  int tests    = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_waddr(id_waddr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken), .stall(stall), .flush_if_id(flush_if_id),
    .flush_id_exe(flush_id_exe), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.DEPTH(5), .LOAD_LAT(4), .CNT_W(4)) dut5 (
    .clk(clk), .rst(rst), .enable(enable), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_waddr(id_waddr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken), .stall(stall5), .flush_if_id(flush_if_id5),
    .flush_id_exe(flush_id_exe5), .fwd_a(fwd_a5), .fwd_b(fwd_b5),
    .stall_cnt(stall_cnt5), .flush_cnt(flush_cnt5)
  );

  // Reference model: the in-flight instructions after ID, youngest at the queue front.
  typedef struct {
    bit valid;
    int waddr;
    bit rw;
    bit mr;
  } instr_t;

  instr_t pipe0[$];
  instr_t pipe1[$];
  int     depth_c [2] = '{3, 5};
  int     lat_c   [2] = '{2, 4};
  int     cntw_c  [2] = '{32, 4};
  longint m_stall_cnt [2];
  longint m_flush_cnt [2];

  function automatic instr_t stage(int c, int k);
    return (c == 0) ? pipe0[k-1] : pipe1[k-1];
  endfunction

  function automatic void model_clear(int c);
    instr_t b;
    b = '{valid: 1'b0, waddr: 0, rw: 1'b0, mr: 1'b0};
    if (c == 0) pipe0.delete(); else pipe1.delete();
    for (int k = 0; k < depth_c[c]; k++) begin
      if (c == 0) pipe0.push_back(b); else pipe1.push_back(b);
    end
    m_stall_cnt[c] = 0;
    m_flush_cnt[c] = 0;
  endfunction

  function automatic int youngest(int c, int r, bit use_r);
    instr_t e;
    if (!use_r || r == 0) return 0;
    for (int k = 1; k <= depth_c[c]; k++) begin
      e = stage(c, k);
      if (e.valid && e.rw && e.waddr == r) return k;
    end
    return 0;
  endfunction

  function automatic bit exp_flush(int c);
    return (branch_taken === 1'b1) && stage(c, 1).valid;
  endfunction

  function automatic bit exp_stall(int c);
    int  ka, kb;
    bit  hazard;
    ka = youngest(c, int'(id_rs), id_use_rs === 1'b1);
    kb = youngest(c, int'(id_rt), id_use_rt === 1'b1);
    hazard = (ka != 0 && stage(c, ka).mr && ka < lat_c[c]) ||
             (kb != 0 && stage(c, kb).mr && kb < lat_c[c]);
    return hazard && !exp_flush(c);
  endfunction

  function automatic logic [10:0] exp_vec(int c);
    int ka, kb;
    ka = youngest(c, int'(id_rs), id_use_rs === 1'b1);
    kb = youngest(c, int'(id_rt), id_use_rt === 1'b1);
    return {exp_stall(c), exp_flush(c), exp_flush(c), 4'(ka), 4'(kb)};
  endfunction

  function automatic logic [149:0] exp_all();
    return {exp_vec(0), exp_vec(1),
            32'(m_stall_cnt[0]), 32'(m_flush_cnt[0]),
            32'(m_stall_cnt[1]), 32'(m_flush_cnt[1])};
  endfunction

  function automatic logic [149:0] obs_all();
    return {stall, flush_if_id, flush_id_exe, 4'(fwd_a), 4'(fwd_b),
            stall5, flush_if_id5, flush_id_exe5, 4'(fwd_a5), 4'(fwd_b5),
            stall_cnt, flush_cnt, 28'd0, stall_cnt5, 28'd0, flush_cnt5};
  endfunction

  function automatic void model_step(int c, bit st, bit fl);
    instr_t n;
    longint maxv;
    maxv = (longint'(1) << cntw_c[c]) - 1;
    if (rst === 1'b1) begin
      model_clear(c);
      return;
    end
    if (enable !== 1'b1) return;
    n.valid = (id_valid === 1'b1) && !st && !fl;
    n.waddr = int'(id_waddr);
    n.rw    = (id_reg_write === 1'b1);
    n.mr    = (id_mem_read === 1'b1);
    if (c == 0) begin
      pipe0.push_front(n);
      void'(pipe0.pop_back());
    end else begin
      pipe1.push_front(n);
      void'(pipe1.pop_back());
    end
    if (st && m_stall_cnt[c] < maxv) m_stall_cnt[c]++;
    if (fl && m_flush_cnt[c] < maxv) m_flush_cnt[c]++;
  endfunction

  // One clock: decide stall/flush from pre-edge state, then advance model and DUT together.
  task automatic advance();
    bit st [2];
    bit fl [2];
    for (int c = 0; c < 2; c++) begin
      st[c] = exp_stall(c);
      fl[c] = exp_flush(c);
    end
    @(posedge clk);
    for (int c = 0; c < 2; c++) model_step(c, st[c], fl[c]);
    #2;
  endtask

  task automatic applyStimulus(bit v, int waddr, bit rw, bit mr,
                               int rs, bit urs, int rt, bit urt, bit br);
    id_valid     = v;
    id_waddr     = 5'(waddr);
    id_reg_write = rw;
    id_mem_read  = mr;
    id_rs        = 5'(rs);
    id_use_rs    = urs;
    id_rt        = 5'(rt);
    id_use_rt    = urt;
    branch_taken = br;
  endtask

  task automatic reset_pipe();
    rst    = 1'b1;
    enable = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    enable = 1'b0;
    applyStimulus(1, 3, 1, 1, 3, 1, 3, 1, 1);
    advance();
    advance();
    tests++;
    if ({stall, flush_if_id, flush_id_exe, fwd_a, fwd_b} !== 7'd0 ||
        stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got stall=%b fif=%b fie=%b fa=%0d fb=%0d sc=%0d fc=%0d, expected all 0",
               stall, flush_if_id, flush_id_exe, fwd_a, fwd_b, stall_cnt, flush_cnt);
    end
    tests++;
    if (obs_all() !== exp_all()) begin
      failures++;
      $display("[TB] FAIL reset_model: got %h expected %h", obs_all(), exp_all());
    end
    rst = 1'b0;
  endtask

  task automatic test_alu_forward();
    reset_pipe();
    applyStimulus(1, 3, 1, 0, 1, 1, 2, 1, 0);
    #1;
    tests++;
    if (obs_all() !== exp_all()) begin
      failures++;
      $display("[TB] FAIL alu_fwd_add: got %h expected %h", obs_all(), exp_all());
    end
    advance();
    applyStimulus(1, 4, 1, 0, 3, 1, 2, 1, 0);
    #1;
    tests++;
    if (fwd_a !== 2'd1 || fwd_b !== 2'd0 || stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL alu_fwd_sub: got fa=%0d fb=%0d stall=%b, expected fa=1 fb=0 stall=0", fwd_a, fwd_b, stall);
    end
    tests++;
    if (obs_all() !== exp_all()) begin
      failures++;
      $display("[TB] FAIL alu_fwd_model: got %h expected %h", obs_all(), exp_all());
    end
    advance();
  endtask

  task automatic test_load_use();
    reset_pipe();
    applyStimulus(1, 5, 1, 1, 0, 0, 0, 0, 0);
    advance();
    applyStimulus(1, 6, 1, 0, 1, 1, 5, 1, 0);
    #1;
    tests++;
    if (stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL load_use_stall: got stall=%b, expected 1", stall);
    end
    advance();
    tests++;
    if (stall !== 1'b0 || fwd_b !== 2'd2 || stall_cnt !== 32'd1) begin
      failures++;
      $display("[TB] FAIL load_use_fwd: got stall=%b fb=%0d sc=%0d, expected stall=0 fb=2 sc=1", stall, fwd_b, stall_cnt);
    end
    tests++;
    if (obs_all() !== exp_all()) begin
      failures++;
      $display("[TB] FAIL load_use_model: got %h expected %h", obs_all(), exp_all());
    end
    advance();
  endtask

  task automatic test_youngest();
    reset_pipe();
    applyStimulus(1, 4, 1, 0, 1, 1, 0, 0, 0);
    advance();
    applyStimulus(1, 4, 1, 0, 2, 1, 0, 0, 0);
    advance();
    applyStimulus(1, 7, 1, 0, 4, 1, 4, 1, 0);
    #1;
    tests++;
    if (fwd_a !== 2'd1 || fwd_b !== 2'd1 || stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL youngest_wins: got fa=%0d fb=%0d stall=%b, expected fa=1 fb=1 stall=0", fwd_a, fwd_b, stall);
    end
    tests++;
    if (obs_all() !== exp_all()) begin
      failures++;
      $display("[TB] FAIL youngest_model: got %h expected %h", obs_all(), exp_all());
    end
    advance();
  endtask

  task automatic test_flush_override();
    reset_pipe();
    applyStimulus(1, 5, 1, 1, 0, 0, 0, 0, 0);
    advance();
    applyStimulus(1, 6, 1, 0, 0, 0, 5, 1, 1);
    #1;
    tests++;
    if (stall !== 1'b0 || flush_if_id !== 1'b1 || flush_id_exe !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_override: got stall=%b fif=%b fie=%b, expected 0 1 1", stall, flush_if_id, flush_id_exe);
    end
    advance();
    // EXE now holds the bubble, so this branch is ignored and the load sits in stage 2.
    #1;
    tests++;
    if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0 || flush_id_exe !== 1'b0 || fwd_b !== 2'd2) begin
      failures++;
      $display("[TB] FAIL flush_bubble: got fc=%0d sc=%0d fie=%b fb=%0d, expected fc=1 sc=0 fie=0 fb=2",
               flush_cnt, stall_cnt, flush_id_exe, fwd_b);
    end
    tests++;
    if (obs_all() !== exp_all()) begin
      failures++;
      $display("[TB] FAIL flush_model: got %h expected %h", obs_all(), exp_all());
    end
    advance();
  endtask

  task automatic test_r0_enable();
    reset_pipe();
    applyStimulus(1, 0, 1, 1, 0, 0, 0, 0, 0);
    advance();
    applyStimulus(1, 0, 1, 0, 0, 1, 0, 1, 0);
    #1;
    tests++;
    if (fwd_a !== 2'd0 || fwd_b !== 2'd0 || stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL r0_no_hazard: got fa=%0d fb=%0d stall=%b, expected 0 0 0", fwd_a, fwd_b, stall);
    end
    advance();
    applyStimulus(1, 6, 1, 1, 0, 0, 0, 0, 0);
    advance();
    applyStimulus(1, 8, 1, 0, 6, 1, 0, 0, 0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) advance();
    #1;
    tests++;
    if (stall !== 1'b1 || fwd_a !== 2'd1 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      failures++;
      $display("[TB] FAIL freeze: got stall=%b fa=%0d sc=%0d fc=%0d, expected stall=1 fa=1 sc=0 fc=0",
               stall, fwd_a, stall_cnt, flush_cnt);
    end
    enable = 1'b1;
    advance();
    tests++;
    if (stall !== 1'b0 || fwd_a !== 2'd2 || stall_cnt !== 32'd1) begin
      failures++;
      $display("[TB] FAIL unfreeze: got stall=%b fa=%0d sc=%0d, expected stall=0 fa=2 sc=1", stall, fwd_a, stall_cnt);
    end
    tests++;
    if (obs_all() !== exp_all()) begin
      failures++;
      $display("[TB] FAIL r0_enable_model: got %h expected %h", obs_all(), exp_all());
    end
    advance();
  endtask

  task automatic test_deep_load();
    bit exp_st [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    reset_pipe();
    applyStimulus(1, 7, 1, 1, 0, 0, 0, 0, 0);
    advance();
    applyStimulus(1, 9, 1, 0, 7, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (stall5 !== exp_st[i]) begin
        failures++;
        $display("[TB] FAIL deep_stall cycle %0d: got %b expected %b", i, stall5, exp_st[i]);
      end
      if (i < 3) advance();
    end
    tests++;
    if (fwd_a5 !== 3'd4 || stall_cnt5 !== 4'd3) begin
      failures++;
      $display("[TB] FAIL deep_fwd: got fa=%0d sc=%0d, expected fa=4 sc=3", fwd_a5, stall_cnt5);
    end
    advance();

    reset_pipe();
    applyStimulus(1, 7, 1, 1, 0, 0, 0, 0, 0);
    advance();
    applyStimulus(1, 9, 1, 0, 7, 1, 0, 0, 0);
    advance();
    rst = 1'b1;
    #1;
    tests++;
    if (stall5 !== 1'b1 || stall_cnt5 !== 4'd1) begin
      failures++;
      $display("[TB] FAIL deep_second_stall: got stall=%b sc=%0d, expected stall=1 sc=1", stall5, stall_cnt5);
    end
    advance();
    rst = 1'b0;
    #1;
    tests++;
    if (stall5 !== 1'b0 || fwd_a5 !== 3'd0 || stall_cnt5 !== 4'd0 || flush_cnt5 !== 4'd0) begin
      failures++;
      $display("[TB] FAIL deep_reset: got stall=%b fa=%0d sc=%0d fc=%0d, expected all 0",
               stall5, fwd_a5, stall_cnt5, flush_cnt5);
    end
    tests++;
    if (obs_all() !== exp_all()) begin
      failures++;
      $display("[TB] FAIL deep_model: got %h expected %h", obs_all(), exp_all());
    end
    advance();
  endtask

  task automatic test_saturation();
    reset_pipe();
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, (i % 2) == 1);
      advance();
    end
    tests++;
    if (flush_cnt !== 32'd20 || flush_cnt5 !== 4'd15) begin
      failures++;
      $display("[TB] FAIL saturation: got fc=%0d fc5=%0d, expected fc=20 fc5=15", flush_cnt, flush_cnt5);
    end
  endtask

  task automatic test_random();
    reset_pipe();
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 63) == 0);
      enable = ($urandom_range(0, 9) != 0);
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 6) == 0);
      #1;
      tests++;
      if (obs_all() !== exp_all()) begin
        failures++;
        $display("[TB] FAIL random cycle %0d: got %h expected %h", i, obs_all(), exp_all());
      end
      advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    model_clear(0);
    model_clear(1);
    rst    = 1'b0;
    enable = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    test_reset();
    test_alu_forward();
    test_load_use();
    test_youngest();
    test_flush_override();
    test_r0_enable();
    test_deep_load();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
